// File: rtl/adc_arb_pkg.sv
// adc_arb_pkg: shared types and constants for the ADC burst arbiter.
//   arb_state_t : arbiter FSM state (IDLE waits for a requester, BURST streams one channel)
//   STALL_MAX   : saturation value of the stall counter
//   ch_bits()   : bits needed to encode a channel index (at least 1)
package adc_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam logic [15:0] STALL_MAX = 16'hFFFF;

   function automatic int ch_bits(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
//   REQ   in  WIDTH    request vector
//   LAST  in  CH_BITS  last-served channel; search starts strictly after it
//   SEL   out CH_BITS  first requester after LAST, cyclically
//   VALID out 1        any request present
module rr_pick
   import adc_arb_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int CH_BITS = ch_bits(WIDTH)
) (
   input  logic [WIDTH-1:0]   REQ,
   input  logic [CH_BITS-1:0] LAST,
   output logic [CH_BITS-1:0] SEL,
   output logic               VALID
);

   always_comb begin
      SEL   = '0;
      VALID = 1'b0;
      // Scan from the farthest offset to the nearest so the closest
      // requester after LAST is the one that sticks. Offset WIDTH is LAST
      // itself, which only wins when it is the sole requester.
      for (int k = WIDTH; k >= 1; k--) begin
         if (REQ[(int'(LAST) + k) % WIDTH]) begin
            SEL   = CH_BITS'((int'(LAST) + k) % WIDTH);
            VALID = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adc_burst_arbiter.sv
// adc_burst_arbiter: burst-mode round-robin merge of per-channel ADC FIFOs
// into one word stream with downstream back-pressure.
//   BUS_CLK, BUS_RST_N     clock, async active-low reset
//   ENABLE                 allow grants; low finishes the current word only
//   BURST_LEN              max words per grant (0 treated as 1)
//   WRITE_REQ / DATA_IN    per-channel FWFT FIFO not-empty flags and head words
//   READ_GRANT             one-hot pop strobe back to the channel FIFOs
//   WRITE_OUT / DATA_OUT / CHANNEL_OUT   registered output word, valid, source
//   READY_IN               downstream accept
//   BUSY                   bursting or output register occupied
//   STALL_CNT              saturating count of valid-but-not-ready cycles
module adc_burst_arbiter
   import adc_arb_pkg::*;
#(
   parameter  int WIDTH     = 4,
   parameter  int DATA_BITS = 32,
   localparam int CH_BITS   = ch_bits(WIDTH)
) (
   input  logic                       BUS_CLK,
   input  logic                       BUS_RST_N,
   input  logic                       ENABLE,
   input  logic [7:0]                 BURST_LEN,
   input  logic [WIDTH-1:0]           WRITE_REQ,
   input  logic [WIDTH*DATA_BITS-1:0] DATA_IN,
   output logic [WIDTH-1:0]           READ_GRANT,
   output logic                       WRITE_OUT,
   output logic [DATA_BITS-1:0]       DATA_OUT,
   output logic [CH_BITS-1:0]         CHANNEL_OUT,
   input  logic                       READY_IN,
   output logic                       BUSY,
   output logic [15:0]                STALL_CNT
);

   arb_state_t           state, state_nxt;
   logic [CH_BITS-1:0]   last_ptr;     // doubles as the selected channel while in BURST
   logic [CH_BITS-1:0]   pick_sel;
   logic                 pick_valid;
   logic [7:0]           burst_cnt;
   logic [7:0]           burst_max;
   logic                 sel_req;
   logic [DATA_BITS-1:0] sel_data;
   logic                 load_ok;
   logic                 grant;
   logic                 last_word;

   rr_pick #(
      .WIDTH   (WIDTH),
      .CH_BITS (CH_BITS)
   ) u_pick (
      .REQ   (WRITE_REQ),
      .LAST  (last_ptr),
      .SEL   (pick_sel),
      .VALID (pick_valid)
   );

   assign sel_req   = WRITE_REQ[last_ptr];
   assign sel_data  = DATA_IN[int'(last_ptr)*DATA_BITS +: DATA_BITS];
   assign load_ok   = !WRITE_OUT || READY_IN;
   assign grant     = (state == BURST) && sel_req && load_ok && ENABLE;
   assign burst_max = (BURST_LEN == 8'd0) ? 8'd1 : BURST_LEN;
   // >= rather than == so shrinking BURST_LEN below the running count
   // still ends the burst on the next grant.
   assign last_word = ({1'b0, burst_cnt} + 9'd1) >= {1'b0, burst_max};

   // FSM: state register
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) state <= IDLE;
      else            state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ENABLE && pick_valid) state_nxt = BURST;
         BURST:   if ((grant && last_word) || !sel_req || !ENABLE) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      READ_GRANT = '0;
      if (grant) READ_GRANT[last_ptr] = 1'b1;
      BUSY = (state == BURST) || WRITE_OUT;
   end

   // Pointer and burst counter. Reset pointer to WIDTH-1 so channel 0 wins first.
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         last_ptr  <= CH_BITS'(WIDTH - 1);
         burst_cnt <= '0;
      end else if (state == IDLE && state_nxt == BURST) begin
         last_ptr  <= pick_sel;
         burst_cnt <= '0;
      end else if (grant) begin
         burst_cnt <= burst_cnt + 8'd1;
      end
   end

   // Output register: load on grant, drain when accepted, hold under back-pressure.
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         WRITE_OUT   <= 1'b0;
         DATA_OUT    <= '0;
         CHANNEL_OUT <= '0;
      end else if (grant) begin
         WRITE_OUT   <= 1'b1;
         DATA_OUT    <= sel_data;
         CHANNEL_OUT <= last_ptr;
      end else if (READY_IN) begin
         WRITE_OUT   <= 1'b0;
      end
   end

   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N)
         STALL_CNT <= '0;
      else if (WRITE_OUT && !READY_IN && STALL_CNT != STALL_MAX)
         STALL_CNT <= STALL_CNT + 16'd1;
   end

endmodule

// File: tb/tb_adc_burst_arbiter.sv
// tb_adc_burst_arbiter: self-checking bench for adc_burst_arbiter.
// Channel FIFOs are modelled as arrays with head/tail indices; the expected
// output stream is derived from FIFO contents with a round-robin burst model.
module tb_adc_burst_arbiter;

   localparam int W  = 4;
   localparam int DB = 32;
   localparam int CB = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            enable;
   logic [7:0]      burst_len;
   logic [W-1:0]    write_req;
   logic [W*DB-1:0] data_in;
   logic [W-1:0]    read_grant;
   logic            write_out;
   logic [DB-1:0]   data_out;
   logic [CB-1:0]   channel_out;
   logic            ready_in;
   logic            busy;
   logic [15:0]     stall_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   adc_burst_arbiter #(.WIDTH(W), .DATA_BITS(DB)) dut (
      .BUS_CLK     (clk),
      .BUS_RST_N   (rst_n),
      .ENABLE      (enable),
      .BURST_LEN   (burst_len),
      .WRITE_REQ   (write_req),
      .DATA_IN     (data_in),
      .READ_GRANT  (read_grant),
      .WRITE_OUT   (write_out),
      .DATA_OUT    (data_out),
      .CHANNEL_OUT (channel_out),
      .READY_IN    (ready_in),
      .BUSY        (busy),
      .STALL_CNT   (stall_cnt)
   );

   // ---------------- channel FIFO models (FWFT) ----------------
   logic [31:0] fmem [W][256];
   int          fhead [W] = '{0, 0, 0, 0};
   int          ftail [W] = '{0, 0, 0, 0};

   always @(posedge clk)
      for (int i = 0; i < W; i++)
         if (read_grant[i]) fhead[i] <= fhead[i] + 1;

   always_comb begin
      write_req = '0;
      data_in   = '0;
      for (int i = 0; i < W; i++) begin
         write_req[i]       = (ftail[i] != fhead[i]);
         data_in[i*DB +: DB] = fmem[i][fhead[i] % 256];
      end
   end

   // ---------------- monitor (samples on falling edge) ----------------
   int          cyc_cnt = 0;
   logic [31:0] cap_data [1024];
   int          cap_ch   [1024];
   int          cap_cyc  [1024];
   int          cap_n    = 0;
   int          gcnt [W] = '{0, 0, 0, 0};
   int          gviol    = 0;
   int          stall_obs = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk) begin
      if (write_out && ready_in && cap_n < 1024) begin
         cap_data[cap_n] <= data_out;
         cap_ch[cap_n]   <= int'(channel_out);
         cap_cyc[cap_n]  <= cyc_cnt;
         cap_n           <= cap_n + 1;
      end
      for (int i = 0; i < W; i++)
         if (read_grant[i]) gcnt[i] <= gcnt[i] + 1;
      if (|read_grant && write_out && !ready_in) gviol <= gviol + 1;
      if (write_out && !ready_in) stall_obs <= stall_obs + 1;
   end

   // ---------------- reference model ----------------
   logic [31:0] exp_data [1024];
   int          exp_ch   [1024];
   int          exp_n;

   // Expected stream after reset with ENABLE high and no refills: visit
   // channels round-robin starting after W-1, take up to max(bl,1) words each.
   task automatic model_stream(input int bl);
      int rem [W];
      int pos [W];
      int last, take, c;
      exp_n = 0;
      last  = W - 1;
      take  = (bl == 0) ? 1 : bl;
      for (int i = 0; i < W; i++) begin
         rem[i] = ftail[i] - fhead[i];
         pos[i] = fhead[i];
      end
      for (int it = 0; it < 1024; it++) begin
         c = -1;
         for (int k = 1; k <= W; k++)
            if (c < 0 && rem[(last + k) % W] > 0) c = (last + k) % W;
         if (c < 0) break;
         for (int j = 0; j < take && rem[c] > 0; j++) begin
            exp_data[exp_n] = fmem[c][pos[c] % 256];
            exp_ch[exp_n]   = c;
            exp_n++;
            pos[c]++;
            rem[c]--;
         end
         last = c;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic push(input int ch, input logic [31:0] d);
      fmem[ch][ftail[ch] % 256] = d;
      ftail[ch]++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_words(input int target, input int bound);
      for (int i = 0; i < bound && cap_n < target; i++) tick();
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      enable    = 1'b1;
      ready_in  = 1'b1;
      burst_len = 8'd1;
      #1;
      for (int i = 0; i < W; i++) ftail[i] = fhead[i];
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b1; ready_in = 1'b1; burst_len = 8'd1;
      #2;
      checks++; if (write_out !== 1'b0)   begin failures++; $display("FAIL rst_write_out: got %b expected 0", write_out); end
      checks++; if (data_out !== '0)      begin failures++; $display("FAIL rst_data_out: got %h expected 0", data_out); end
      checks++; if (channel_out !== '0)   begin failures++; $display("FAIL rst_channel_out: got %0d expected 0", channel_out); end
      checks++; if (stall_cnt !== 16'h0)  begin failures++; $display("FAIL rst_stall_cnt: got %h expected 0", stall_cnt); end
      checks++; if (read_grant !== '0)    begin failures++; $display("FAIL rst_read_grant: got %b expected 0000", read_grant); end
      checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_burst();
      int base, g0, c0;
      int gap_exp [4] = '{1, 1, 2, 1};
      do_reset();
      burst_len = 8'd3;
      base = cap_n; g0 = gcnt[1]; c0 = cyc_cnt;
      for (int k = 0; k < 5; k++) push(1, 32'hA + k);
      @(negedge clk);
      checks++; if (read_grant !== 4'b0000) begin failures++; $display("FAIL single_cycle0_grant: got %b expected 0000", read_grant); end
      @(negedge clk);
      checks++; if (read_grant !== 4'b0010) begin failures++; $display("FAIL single_cycle1_grant: got %b expected 0010", read_grant); end
      wait_words(base + 5, 40);
      tick(); tick();
      checks++; if (cap_n != base + 5) begin failures++; $display("FAIL single_count: got %0d expected %0d", cap_n - base, 5); end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (cap_data[base+k] !== 32'hA + k || cap_ch[base+k] != 1) begin
            failures++; $display("FAIL single_word%0d: got %h/ch%0d expected %h/ch1", k, cap_data[base+k], cap_ch[base+k], 32'hA + k);
         end
      end
      checks++; if (cap_cyc[base] - c0 != 2) begin failures++; $display("FAIL single_latency: got %0d expected 2", cap_cyc[base] - c0); end
      for (int k = 1; k < 5; k++) begin
         checks++;
         if (cap_cyc[base+k] - cap_cyc[base+k-1] != gap_exp[k-1]) begin
            failures++; $display("FAIL single_gap%0d: got %0d expected %0d", k, cap_cyc[base+k] - cap_cyc[base+k-1], gap_exp[k-1]);
         end
      end
      checks++; if (gcnt[1] - g0 != 5) begin failures++; $display("FAIL single_pops: got %0d expected 5", gcnt[1] - g0); end
   endtask

   task automatic test_all_busy();
      int base;
      do_reset();
      burst_len = 8'd2;
      for (int ch = 0; ch < W; ch++)
         for (int k = 0; k < 6; k++) push(ch, 32'h100 * ch + k);
      model_stream(2);
      base = cap_n;
      wait_words(base + exp_n, 200);
      checks++; if (cap_n != base + exp_n) begin failures++; $display("FAIL busy_count: got %0d expected %0d", cap_n - base, exp_n); end
      for (int k = 0; k < exp_n; k++) begin
         checks++;
         if (cap_data[base+k] !== exp_data[k] || cap_ch[base+k] != exp_ch[k]) begin
            failures++; $display("FAIL busy_word%0d: got %h/ch%0d expected %h/ch%0d", k, cap_data[base+k], cap_ch[base+k], exp_data[k], exp_ch[k]);
         end
      end
      for (int k = 1; k < exp_n; k++) begin
         checks++;
         if (cap_cyc[base+k] - cap_cyc[base+k-1] != ((k % 2 == 0) ? 2 : 1)) begin
            failures++; $display("FAIL busy_gap%0d: got %0d expected %0d", k, cap_cyc[base+k] - cap_cyc[base+k-1], (k % 2 == 0) ? 2 : 1);
         end
      end
   endtask

   task automatic test_backpressure();
      int base;
      logic [31:0] held;
      do_reset();
      burst_len = 8'd8;
      for (int k = 0; k < 10; k++) push(2, 32'hB000 + k);
      model_stream(8);
      base = cap_n;
      for (int i = 0; i < 10 && !write_out; i++) tick();
      tick();
      checks++; if (write_out !== 1'b1) begin failures++; $display("FAIL bp_started: got %b expected 1", write_out); end
      held = data_out;
      ready_in = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         checks++;
         if (data_out !== held || read_grant !== '0 || write_out !== 1'b1) begin
            failures++; $display("FAIL bp_hold%0d: got data %h grant %b valid %b expected data %h grant 0000 valid 1", i, data_out, read_grant, write_out, held);
         end
         tick();
      end
      checks++; if (stall_cnt !== 16'd7) begin failures++; $display("FAIL bp_stall_cnt: got %0d expected 7", stall_cnt); end
      ready_in = 1'b1;
      wait_words(base + exp_n, 60);
      checks++; if (cap_n != base + exp_n) begin failures++; $display("FAIL bp_count: got %0d expected %0d", cap_n - base, exp_n); end
      for (int k = 0; k < exp_n; k++) begin
         checks++;
         if (cap_data[base+k] !== exp_data[k] || cap_ch[base+k] != exp_ch[k]) begin
            failures++; $display("FAIL bp_word%0d: got %h/ch%0d expected %h/ch%0d", k, cap_data[base+k], cap_ch[base+k], exp_data[k], exp_ch[k]);
         end
      end
   endtask

   task automatic test_enable_drop();
      int base, g0;
      do_reset();
      burst_len = 8'd8;
      for (int k = 0; k < 8; k++) push(0, 32'hC000 + k);
      base = cap_n; g0 = gcnt[0];
      for (int i = 0; i < 20 && gcnt[0] - g0 < 2; i++) tick();
      enable = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL en_busy_during: got %b expected 1", busy); end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++; if (read_grant !== '0) begin failures++; $display("FAIL en_no_grant%0d: got %b expected 0000", i, read_grant); end
         tick();
      end
      checks++; if (gcnt[0] - g0 != 2) begin failures++; $display("FAIL en_pops: got %0d expected 2", gcnt[0] - g0); end
      checks++; if (cap_n - base != 2 || cap_data[base] !== 32'hC000 || cap_data[base+1] !== 32'hC001) begin
         failures++; $display("FAIL en_words: got n=%0d %h %h expected n=2 c000 c001", cap_n - base, cap_data[base], cap_data[base+1]);
      end
      checks++; if (busy !== 1'b0 || write_out !== 1'b0) begin failures++; $display("FAIL en_busy_after: got busy %b valid %b expected 0 0", busy, write_out); end
      enable = 1'b1;
   endtask

   task automatic test_async_reset();
      int base;
      do_reset();
      burst_len = 8'd4;
      for (int k = 0; k < 6; k++) push(2, 32'hD200 + k);
      for (int i = 0; i < 10 && !write_out; i++) tick();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (write_out !== 1'b0 || data_out !== '0 || channel_out !== '0) begin
         failures++; $display("FAIL arst_outputs: got valid %b data %h ch %0d expected 0 0 0", write_out, data_out, channel_out);
      end
      checks++; if (read_grant !== '0 || busy !== 1'b0 || stall_cnt !== 16'h0) begin
         failures++; $display("FAIL arst_ctrl: got grant %b busy %b stall %0d expected 0000 0 0", read_grant, busy, stall_cnt);
      end
      for (int i = 0; i < W; i++) ftail[i] = fhead[i];
      #1 rst_n = 1'b1;
      tick();
      base = cap_n;
      push(2, 32'hE200);
      push(0, 32'hE000);
      @(negedge clk);
      @(negedge clk);
      checks++; if (read_grant !== 4'b0001) begin failures++; $display("FAIL arst_first_grant: got %b expected 0001", read_grant); end
      wait_words(base + 2, 30);
      checks++; if (cap_n - base != 2 || cap_ch[base] != 0 || cap_ch[base+1] != 2) begin
         failures++; $display("FAIL arst_order: got n=%0d ch%0d,ch%0d expected n=2 ch0,ch2", cap_n - base, cap_ch[base], cap_ch[base+1]);
      end
   endtask

   task automatic test_burst_len_zero();
      int base;
      do_reset();
      burst_len = 8'd0;
      for (int k = 0; k < 3; k++) begin
         push(1, 32'hF100 + k);
         push(3, 32'hF300 + k);
      end
      model_stream(0);
      base = cap_n;
      wait_words(base + exp_n, 60);
      checks++; if (cap_n != base + exp_n) begin failures++; $display("FAIL bl0_count: got %0d expected %0d", cap_n - base, exp_n); end
      for (int k = 0; k < exp_n; k++) begin
         checks++;
         if (cap_data[base+k] !== exp_data[k] || cap_ch[base+k] != exp_ch[k]) begin
            failures++; $display("FAIL bl0_word%0d: got %h/ch%0d expected %h/ch%0d", k, cap_data[base+k], cap_ch[base+k], exp_data[k], exp_ch[k]);
         end
      end
      for (int k = 1; k < exp_n; k++) begin
         checks++;
         if (cap_cyc[base+k] - cap_cyc[base+k-1] != 2) begin
            failures++; $display("FAIL bl0_gap%0d: got %0d expected 2", k, cap_cyc[base+k] - cap_cyc[base+k-1]);
         end
      end
   endtask

   task automatic test_stall_saturate();
      do_reset();
      ready_in = 1'b0;
      push(0, 32'h5A5A0000);
      for (int i = 0; i < 10 && !write_out; i++) tick();
      repeat (65534) @(posedge clk);
      #1;
      checks++; if (stall_cnt !== 16'hFFFE) begin failures++; $display("FAIL sat_fffe: got %h expected fffe", stall_cnt); end
      tick();
      checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_ffff: got %h expected ffff", stall_cnt); end
      tick(); tick(); tick();
      checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold: got %h expected ffff", stall_cnt); end
      checks++; if (data_out !== 32'h5A5A0000 || write_out !== 1'b1) begin
         failures++; $display("FAIL sat_word: got %h valid %b expected 5a5a0000 valid 1", data_out, write_out);
      end
      ready_in = 1'b1;
      tick();
      checks++; if (write_out !== 1'b0) begin failures++; $display("FAIL sat_drain: got %b expected 0", write_out); end
   endtask

   task automatic test_random();
      int base, sbase, vbase, bl, n;
      for (int it = 0; it < 6; it++) begin
         do_reset();
         bl = $urandom_range(0, 4);
         burst_len = 8'(bl);
         for (int ch = 0; ch < W; ch++) begin
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) push(ch, $urandom);
         end
         model_stream(bl);
         base = cap_n; sbase = stall_obs; vbase = gviol;
         for (int c = 0; c < 500 && cap_n < base + exp_n; c++) begin
            ready_in = ($urandom_range(0, 3) != 0);
            tick();
         end
         ready_in = 1'b1;
         tick();
         checks++; if (cap_n != base + exp_n) begin failures++; $display("FAIL rnd%0d_count: got %0d expected %0d", it, cap_n - base, exp_n); end
         for (int k = 0; k < exp_n; k++) begin
            checks++;
            if (cap_data[base+k] !== exp_data[k] || cap_ch[base+k] != exp_ch[k]) begin
               failures++; $display("FAIL rnd%0d_word%0d: got %h/ch%0d expected %h/ch%0d", it, k, cap_data[base+k], cap_ch[base+k], exp_data[k], exp_ch[k]);
            end
         end
         checks++; if (int'(stall_cnt) != stall_obs - sbase) begin failures++; $display("FAIL rnd%0d_stall: got %0d expected %0d", it, stall_cnt, stall_obs - sbase); end
         checks++; if (gviol != vbase) begin failures++; $display("FAIL rnd%0d_grant_in_stall: got %0d expected 0", it, gviol - vbase); end
      end
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_burst();
      test_all_busy();
      test_backpressure();
      test_enable_drop();
      test_async_reset();
      test_burst_len_zero();
      test_random();
      test_stall_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
